// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state encoding and default line settings
// used by the receiver, transmitter and register block.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

    localparam int DEFAULT_CLK_HZ = 12_000_000;
    localparam int DEFAULT_BAUD   = 9600;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous first-word-fall-through FIFO with an explicit occupancy count.
module byte_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [WIDTH-1:0]      din,
    input  logic                  pop,
    output logic [WIDTH-1:0]      dout,
    output logic                  valid,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign valid  = (count != '0);
    assign full   = (count == (DEPTH_LOG2 + 1)'(DEPTH));
    assign do_pop = pop && valid;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 serial receiver: synchronises and deserialises the rx pin and buffers
// received bytes in a byte_fifo with sticky overrun/framing error flags.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = DEFAULT_CLK_HZ,
    parameter int BAUD       = DEFAULT_BAUD,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rx,
    input  logic                rd,
    input  logic                clr_err,
    output logic [7:0]          data_out,
    output logic                valid,
    output logic                full,
    output logic [DEPTH_LOG2:0] count,
    output logic                overrun,
    output logic                frame_err
);
    localparam int          DIV       = CLK_HZ / BAUD;
    localparam logic [15:0] HALF_LOAD = 16'(DIV / 2 - 1);
    localparam logic [15:0] FULL_LOAD = 16'(DIV - 1);

    logic        rx_meta, rx_s, rx_prev, armed;
    logic [1:0]  settle;
    rx_state_t   state, state_next;
    logic [15:0] baud_cnt, baud_cnt_next;
    logic [2:0]  bit_idx, bit_idx_next;
    logic [7:0]  shift, shift_next;
    logic        tick, fall, stop_ok, stop_bad, overrun_set;

    assign tick = (baud_cnt == 16'd0);
    assign fall = armed && rx_prev && !rx_s;

    // The edge detector only arms once a genuine high has been sampled, so a
    // line held low through reset cannot fake a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
            settle  <= 2'b00;
            armed   <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
            settle  <= {settle[0], 1'b1};
            armed   <= armed | (settle[1] & rx_s);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= 16'd0;
            bit_idx  <= 3'd0;
            shift    <= 8'd0;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_cnt_next;
            bit_idx  <= bit_idx_next;
            shift    <= shift_next;
        end
    end

    always_comb begin
        state_next    = state;
        baud_cnt_next = tick ? 16'd0 : baud_cnt - 16'd1;
        bit_idx_next  = bit_idx;
        shift_next    = shift;
        stop_ok       = 1'b0;
        stop_bad      = 1'b0;
        case (state)
            IDLE: begin
                if (fall) begin
                    baud_cnt_next = HALF_LOAD;
                    state_next    = START;
                end
            end
            START: begin
                if (tick) begin
                    if (!rx_s) begin
                        baud_cnt_next = FULL_LOAD;
                        bit_idx_next  = 3'd0;
                        state_next    = DATA;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    shift_next    = {rx_s, shift[7:1]};
                    baud_cnt_next = FULL_LOAD;
                    bit_idx_next  = bit_idx + 3'd1;
                    if (bit_idx == 3'd7)
                        state_next = STOP;
                end
            end
            STOP: begin
                // Returning to IDLE mid stop bit leaves half a bit to resync.
                if (tick) begin
                    stop_ok    = rx_s;
                    stop_bad   = !rx_s;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign overrun_set = stop_ok && full && !rd;

    always_ff @(posedge clk) begin
        if (reset) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overrun   <= (overrun && !clr_err) || overrun_set;
            frame_err <= (frame_err && !clr_err) || stop_bad;
        end
    end

    byte_fifo #(
        .WIDTH      (8),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (stop_ok),
        .din   (shift),
        .pop   (rd),
        .dout  (data_out),
        .valid (valid),
        .full  (full),
        .count (count)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed corner cases, a frame table
// and random traffic compared against a queue-based reference model.
module tb_uart_rx_fifo;
    localparam int CLK_HZ     = 12_000_000;
    localparam int BAUD       = 300_000;
    localparam int DIV        = CLK_HZ / BAUD;
    localparam int DEPTH_LOG2 = 4;
    localparam int DEPTH      = 2 ** DEPTH_LOG2;
    localparam int PUSH_LAT   = 3 + (19 * DIV) / 2;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                rx = 1'b1;
    logic                rd = 1'b0;
    logic                clr_err = 1'b0;
    logic [7:0]          data_out;
    logic                valid, full, overrun, frame_err;
    logic [DEPTH_LOG2:0] count;

    int checks   = 0;
    int failures = 0;

    logic [7:0] model_q[$];
    logic       model_ovr;
    logic       model_ferr;

    int lat;
    bit seen;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_count;
        logic       exp_ferr;
        logic [7:0] exp_head;
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .rd        (rd),
        .clr_err   (clr_err),
        .data_out  (data_out),
        .valid     (valid),
        .full      (full),
        .count     (count),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic check_state(input string tag);
        int n;
        n = model_q.size();
        check_output({tag, "_valid"}, 32'(valid), 32'(n > 0));
        check_output({tag, "_full"}, 32'(full), 32'(n == DEPTH));
        check_output({tag, "_count"}, 32'(count), 32'(n));
        check_output({tag, "_data"}, 32'(data_out), (n > 0) ? 32'(model_q[0]) : 32'd0);
        check_output({tag, "_overrun"}, 32'(overrun), 32'(model_ovr));
        check_output({tag, "_frame_err"}, 32'(frame_err), 32'(model_ferr));
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (DIV) step();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (DIV) step();
        end
        rx = stop_bit;
        repeat (DIV) step();
        rx = 1'b1;
        repeat (4) step();
    endtask

    task automatic model_frame(input logic [7:0] b, input logic stop_bit);
        if (!stop_bit)
            model_ferr = 1'b1;
        else if (model_q.size() == DEPTH)
            model_ovr = 1'b1;
        else
            model_q.push_back(b);
    endtask

    task automatic apply_stimulus(input logic [7:0] b, input logic stop_bit);
        send_frame(b, stop_bit);
        model_frame(b, stop_bit);
    endtask

    task automatic pop_one();
        rd = 1'b1;
        step();
        rd = 1'b0;
        if (model_q.size() > 0)
            void'(model_q.pop_front());
    endtask

    task automatic clear_errors();
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        model_ovr  = 1'b0;
        model_ferr = 1'b0;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        rx      = 1'b1;
        rd      = 1'b0;
        clr_err = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        repeat (4) step();
        model_q.delete();
        model_ovr  = 1'b0;
        model_ferr = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{8'h55, 1'b1, 1, 1'b0, 8'h55};
        vecs[1] = '{8'hA3, 1'b1, 2, 1'b0, 8'h55};
        vecs[2] = '{8'h41, 1'b0, 2, 1'b1, 8'h55};
        vecs[3] = '{8'h00, 1'b1, 3, 1'b1, 8'h55};
        vecs[4] = '{8'hFF, 1'b1, 4, 1'b1, 8'h55};

        do_reset();
        check_state("reset");

        // Single frame: push latency, first-word fall-through, pop to empty.
        fork
            send_frame(8'h55, 1'b1);
            begin
                lat  = 0;
                seen = 0;
                for (int n = 1; n <= 12 * DIV && !seen; n++) begin
                    step();
                    if (valid === 1'b1) begin
                        seen = 1;
                        lat  = n;
                    end
                end
            end
        join
        model_frame(8'h55, 1'b1);
        check_output("t1_valid_seen", 32'(seen), 32'd1);
        if (seen)
            check_output("t1_latency_in_window", 32'(lat >= PUSH_LAT - 2 && lat <= PUSH_LAT + 2), 32'd1);
        check_output("t1_data", 32'(data_out), 32'h55);
        check_output("t1_count", 32'(count), 32'd1);
        pop_one();
        check_output("t1_valid_after_pop", 32'(valid), 32'd0);
        check_output("t1_data_after_pop", 32'(data_out), 32'h00);

        // Frame table, including a framing error in the middle.
        do_reset();
        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].data, vecs[i].stop);
            check_output("tbl_count", 32'(count), 32'(vecs[i].exp_count));
            check_output("tbl_frame_err", 32'(frame_err), 32'(vecs[i].exp_ferr));
            check_output("tbl_head", 32'(data_out), 32'(vecs[i].exp_head));
        end
        while (model_q.size() > 0) begin
            pop_one();
            check_state("tbl_pop");
        end

        // Overflow: sixteen bytes fill the FIFO, the seventeenth is dropped.
        do_reset();
        for (int i = 0; i < DEPTH; i++)
            apply_stimulus(8'(i), 1'b1);
        apply_stimulus(8'hAA, 1'b1);
        check_output("t2_full", 32'(full), 32'd1);
        check_output("t2_count", 32'(count), 32'd16);
        check_output("t2_overrun", 32'(overrun), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            check_output("t2_pop_order", 32'(data_out), 32'(i));
            pop_one();
        end
        check_state("t2_drained");

        // Framing error, clear, then a clean frame.
        do_reset();
        apply_stimulus(8'h41, 1'b0);
        check_output("t3_frame_err", 32'(frame_err), 32'd1);
        check_output("t3_count", 32'(count), 32'd0);
        clear_errors();
        check_output("t3_frame_err_cleared", 32'(frame_err), 32'd0);
        apply_stimulus(8'h42, 1'b1);
        check_output("t3_data", 32'(data_out), 32'h42);
        check_state("t3_after");
        pop_one();

        // Short low glitch must not start a frame.
        rx = 1'b0;
        repeat (DIV / 4) step();
        rx = 1'b1;
        repeat (2 * DIV) step();
        check_state("t4_glitch");
        apply_stimulus(8'h5A, 1'b1);
        check_state("t4_after");
        pop_one();

        // Full FIFO with rd on the exact push cycle of the next frame.
        do_reset();
        for (int i = 0; i < DEPTH; i++)
            apply_stimulus(8'h60 + 8'(i), 1'b1);
        fork
            send_frame(8'h77, 1'b1);
            begin
                repeat (PUSH_LAT - 1) step();
                rd = 1'b1;
                step();
                rd = 1'b0;
            end
        join
        void'(model_q.pop_front());
        model_q.push_back(8'h77);
        check_output("t5_count", 32'(count), 32'd16);
        check_output("t5_overrun", 32'(overrun), 32'd0);
        check_state("t5_state");
        for (int i = 0; i < DEPTH; i++) begin
            check_output("t5_pop_order", 32'(data_out), (i == DEPTH - 1) ? 32'h77 : 32'(8'h61 + 8'(i)));
            pop_one();
        end

        // Reset mid-frame with the line held low.
        do_reset();
        rx = 1'b0;
        repeat (3 * DIV) step();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        model_q.delete();
        model_ovr  = 1'b0;
        model_ferr = 1'b0;
        repeat (12 * DIV) step();
        check_state("t6_held_low");
        rx = 1'b1;
        repeat (2 * DIV) step();
        apply_stimulus(8'h3C, 1'b1);
        check_output("t6_data", 32'(data_out), 32'h3C);
        check_state("t6_after");

        // Random traffic: fill first, then mixed pops and error clears.
        do_reset();
        for (int iter = 0; iter < 40; iter++) begin
            logic [7:0] b;
            logic       s;
            int         npop;
            b = 8'($urandom);
            s = ($urandom_range(0, 7) != 0);
            apply_stimulus(b, s);
            check_state("rnd_frame");
            npop = (iter < 20) ? 0 : int'($urandom_range(0, 4));
            for (int p = 0; p < npop; p++) begin
                pop_one();
                check_state("rnd_pop");
            end
            if ($urandom_range(0, 3) == 0) begin
                clear_errors();
                check_state("rnd_clr");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Serial receive front end feeding the 8251-style register block: oversamples the raw rx pin, deserialises 8N1 frames and buffers received bytes in a small FIFO. The register block pops bytes with a one-cycle read strobe and reports valid/full/error status to the CPU. This replaces the single-byte receive buffer so that console bursts at 9600 baud are not lost while the CPU is busy.

Parameters:
CLK_HZ, 12000000, system clock frequency in Hz
BAUD, 9600, line rate; DIV = CLK_HZ/BAUD (1250 at defaults), must be >= 4
DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 bytes (16)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
rx  in  1  raw asynchronous serial input, idle high
rd  in  1  pop strobe, one cycle; ignored when valid=0
clr_err  in  1  clears sticky overrun and frame_err
data_out  out  8  head of FIFO (first-word fall-through); 8'h00 when valid=0
valid  out  1  FIFO non-empty
full  out  1  FIFO holds DEPTH bytes
count  out  DEPTH_LOG2+1  bytes held, 0..DEPTH
overrun  out  1  sticky: byte dropped because FIFO full
frame_err  out  1  sticky: stop bit sampled low

Behaviour:
- Reset: rx synchroniser flops and previous-sample flop -> 1; FSM -> IDLE; FIFO pointers/count -> 0; valid=0, full=0, data_out=8'h00, overrun=0, frame_err=0. Reset mid-frame abandons the frame; no partial byte is pushed.
- rx passes a 2-flop synchroniser (rx_s). Falling edge = prev rx_s 1, current rx_s 0. A line held low through reset does not start a frame until it rises and falls again.
- Baud counter: 16-bit down-counter; "tick" when it reaches 0.
- IDLE: on falling edge load counter DIV/2-1 -> START.
- START: on tick sample rx_s; 0 -> load DIV-1, bit index 0 -> DATA; 1 (glitch) -> IDLE, nothing recorded.
- DATA: on tick shift rx_s in LSB first, reload DIV-1; after 8th bit -> STOP.
- STOP: on tick sample rx_s. 1: push byte if FIFO not full (or if rd pops in the same cycle); otherwise drop byte and set overrun. 0: discard byte, set frame_err. Always -> IDLE the next cycle (resync mid stop bit).
- Push latency: byte written at the clock edge ending the STOP tick; valid/count/data_out reflect it the next cycle.
- Pop: rd while valid advances the read pointer; the next entry (or 8'h00 if empty) appears on data_out the next cycle.
- Simultaneous push and pop: when full, push accepted, count stays DEPTH; when empty, rd ignored, push accepted, count -> 1; otherwise count unchanged.
- Pointers are DEPTH_LOG2 bits and wrap modulo DEPTH; count is tracked explicitly.
- Sticky flags: clr_err clears; an error event in the same cycle as clr_err wins (flag stays 1).

Decomposition:
- Shared package uart_pkg: rx FSM state encoding (IDLE, START, DATA, STOP); default CLK_HZ/BAUD constants also used by the transmitter and the register block.
- One sub-module: byte_fifo (parameterised synchronous FWFT FIFO: push, pop, data, valid, full, count), reused later for transmit buffering. The deserialiser FSM stays in uart_rx_fifo.

Test Plan:
- Frame 0x55 at DIV=1250 -> 1250*9.5±2 clocks after start edge valid=1, data_out=0x55, count=1; rd -> valid=0, data_out=0x00.
- 17 frames 0x00..0x0F then 0xAA, no reads -> full=1, count=16, overrun=1; 16 pops return 0x00..0x0F in order, 0xAA never appears.
- Frame 0x41 with stop bit driven 0 -> frame_err=1, count=0; clr_err -> frame_err=0; following frame 0x42 received correctly.
- rx low pulse of 300 clocks (< DIV/2) -> FSM returns to IDLE, count=0, no error flags.
- FIFO full, rd pulsed on the exact push cycle of frame 0x77 -> count stays 16, overrun=0, 0x77 is the last byte popped.
- Reset asserted mid-DATA with rx held low, then released -> no push; no frame starts until rx goes high then low; next full frame 0x3C is received correctly.
